// File: rtl/next_state_if.sv
// next_state_if -- bundle of load/start/data/status signals for next_state.
//   load    : load init_x into the state registers
//   init_x  : initial state words, word j at [32j+31:32j]
//   start   : request one next-state iteration
//   c_flat  : current counter values c0..c7, same packing
//   ctr_en  : one-cycle enable to the eight counter stages
//   x_flat  : state words x0..x7, same packing
//   busy    : iteration in progress
//   done    : one-cycle pulse, new x_flat valid
// master drives requests and data; slave (the block) drives status and x_flat.
interface next_state_if;
  logic         load;
  logic [255:0] init_x;
  logic         start;
  logic [255:0] c_flat;
  logic         ctr_en;
  logic [255:0] x_flat;
  logic         busy;
  logic         done;

  modport master (
    output load, init_x, start, c_flat,
    input  ctr_en, x_flat, busy, done
  );

  modport slave (
    input  load, init_x, start, c_flat,
    output ctr_en, x_flat, busy, done
  );
endinterface

// File: rtl/next_state.sv
// next_state -- one next-state iteration over eight 32-bit state words.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : next_state_if slave (load/init_x/start/c_flat in; ctr_en/x_flat/busy/done out)
// An iteration: ADV pulses ctr_en, CALC forms g0..g7 one per cycle from x and c,
// COMB updates all x words at once, done follows in the next (IDLE) cycle.
module next_state (
  input  logic           clk,
  input  logic           rst,
  next_state_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ADV, CALC, COMB} state_t;

  state_t      state_q, state_d;
  logic [2:0]  j_q, j_d;
  logic        ctr_en_d, busy_d, done_d;
  logic        ctr_en_q, busy_q, done_q;

  logic [31:0] x_q [8];
  logic [31:0] g_q [8];
  logic [31:0] x_new [8];

  logic [31:0] u;
  logic [63:0] s;
  logic [31:0] g_new;

  function automatic logic [31:0] rotl16(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] v);
    return {v[23:0], v[31:24]};
  endfunction

  // g_j for the word selected by j
  always_comb begin
    u     = x_q[j_q] + bus.c_flat[{j_q, 5'd0} +: 32];
    s     = {32'd0, u} * {32'd0, u};
    g_new = s[63:32] ^ s[31:0];
  end

  always_comb begin
    x_new[0] = g_q[0] + rotl16(g_q[7]) + rotl16(g_q[6]);
    x_new[1] = g_q[1] + rotl8(g_q[0])  + g_q[7];
    x_new[2] = g_q[2] + rotl16(g_q[1]) + rotl16(g_q[0]);
    x_new[3] = g_q[3] + rotl8(g_q[2])  + g_q[1];
    x_new[4] = g_q[4] + rotl16(g_q[3]) + rotl16(g_q[2]);
    x_new[5] = g_q[5] + rotl8(g_q[4])  + g_q[3];
    x_new[6] = g_q[6] + rotl16(g_q[5]) + rotl16(g_q[4]);
    x_new[7] = g_q[7] + rotl8(g_q[6])  + g_q[5];
  end

  // Status outputs are registered, so they are derived from the next state.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    if (bus.load) begin
      state_d = IDLE;
      j_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) state_d = ADV;
        ADV: begin
          state_d = CALC;
          j_d     = '0;
        end
        CALC: begin
          j_d = j_q + 3'd1;
          if (j_q == 3'd7) state_d = COMB;
        end
        COMB:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    ctr_en_d = (state_d == ADV);
    busy_d   = (state_d != IDLE);
    done_d   = !bus.load && (state_q == COMB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      ctr_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      ctr_en_q <= ctr_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        x_q[i] <= '0;
        g_q[i] <= '0;
      end
    end else if (bus.load) begin
      for (int unsigned i = 0; i < 8; i++) begin
        x_q[i] <= bus.init_x[i*32 +: 32];
        g_q[i] <= '0;
      end
    end else begin
      if (state_q == CALC) g_q[j_q] <= g_new;
      if (state_q == COMB) begin
        for (int unsigned i = 0; i < 8; i++) x_q[i] <= x_new[i];
      end
    end
  end

  assign bus.ctr_en = ctr_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  for (genvar w = 0; w < 8; w++) begin : g_xout
    assign bus.x_flat[w*32 +: 32] = x_q[w];
  end

endmodule

// File: tb/tb_next_state.sv
module tb_next_state;

  logic clk = 1'b0;
  logic rst;
  next_state_if bus ();

  next_state dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] gfun(input logic [31:0] x, input logic [31:0] c);
    logic [63:0] sq;
    logic [31:0] uu;
    uu = x + c;
    sq = 64'(uu) * 64'(uu);
    return sq[63:32] ^ sq[31:0];
  endfunction

  // Even words take two 16-rotated predecessors, odd words an 8-rotated one plus an unrotated one.
  function automatic logic [255:0] mix(input logic [255:0] g);
    logic [255:0] r;
    logic [31:0] a, b, cc;
    for (int i = 0; i < 8; i++) begin
      a  = g[i*32 +: 32];
      b  = g[((i + 7) % 8)*32 +: 32];
      cc = g[((i + 6) % 8)*32 +: 32];
      if (i % 2 == 0) r[i*32 +: 32] = a + rotl(b, 16) + rotl(cc, 16);
      else            r[i*32 +: 32] = a + rotl(b, 8) + cc;
    end
    return r;
  endfunction

  logic [255:0] mx = '0;
  logic [255:0] mg = '0;
  int           mk = 0;   // cycles since accepted start, 0 when idle
  bit           mdone = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mk = 0; mdone = 1'b0; mx = '0; mg = '0;
      end else begin
        mdone = 1'b0;
        if (bus.load) begin
          mk = 0; mx = bus.init_x; mg = '0;
        end else if (mk == 0) begin
          if (bus.start) mk = 1;
        end else begin
          if (mk >= 2 && mk <= 9)
            mg[(mk-2)*32 +: 32] = gfun(mx[(mk-2)*32 +: 32], bus.c_flat[(mk-2)*32 +: 32]);
          if (mk == 10) begin
            mx = mix(mg); mdone = 1'b1; mk = 0;
          end else mk++;
        end
      end
    end
  end

  // Single compare process: every cycle, against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (compare_on) begin
        chk("cyc_ctr_en", 256'(bus.ctr_en), 256'(mk == 1));
        chk("cyc_busy",   256'(bus.busy),   256'(mk != 0));
        chk("cyc_done",   256'(bus.done),   256'(mdone));
        chk("cyc_x",      bus.x_flat,       mx);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  bit           ce_log   [64];
  bit           busy_log [64];
  bit           done_log [64];
  logic [255:0] x_log    [64];

  function automatic logic [255:0] pack(input logic [31:0] ev, input logic [31:0] od);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = (i % 2 == 0) ? ev : od;
    return r;
  endfunction

  function automatic int count_ones(input int which, input int last);
    int n = 0;
    for (int i = 1; i <= last; i++) begin
      if (which == 0 && ce_log[i])   n++;
      if (which == 1 && busy_log[i]) n++;
      if (which == 2 && done_log[i]) n++;
    end
    return n;
  endfunction

  task automatic do_load(input logic [255:0] v);
    @(negedge clk); #1;
    bus.load = 1'b1; bus.init_x = v;
    @(negedge clk); #1;
    bus.load = 1'b0;
    chk("load_x", bus.x_flat, v);
  endtask

  // Called mid-cycle T; start is high during T and for n < hold, plus cycle T+glitch.
  task automatic iterate(input int hold, input int glitch, input int load_at,
                         input logic [255:0] load_val, input int rst_at, input int ncyc);
    for (int i = 0; i < 64; i++) begin
      ce_log[i] = 0; busy_log[i] = 0; done_log[i] = 0; x_log[i] = '0;
    end
    bus.start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk); #1;
      ce_log[n] = bus.ctr_en; busy_log[n] = bus.busy;
      done_log[n] = bus.done; x_log[n] = bus.x_flat;
      bus.start = (n < hold) || (n == glitch);
      bus.load  = (n == load_at);
      if (n == load_at) bus.init_x = load_val;
      if (n == rst_at) begin
        rst = 1'b1; #1;
        chk("rst_immediate_x", bus.x_flat, '0);
        chk("rst_immediate_busy", 256'(bus.busy), 256'(0));
      end else rst = 1'b0;
    end
    bus.start = 1'b0; bus.load = 1'b0; rst = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [255:0] exp_x);
    chk({tag, "_ctr_en_T1"}, 256'(ce_log[1]), 256'(1));
    chk({tag, "_ctr_en_count"}, 256'(count_ones(0, 16)), 256'(1));
    chk({tag, "_busy_count"}, 256'(count_ones(1, 16)), 256'(10));
    chk({tag, "_busy_T10"}, 256'(busy_log[10]), 256'(1));
    chk({tag, "_done_T11"}, 256'(done_log[11]), 256'(1));
    chk({tag, "_done_count"}, 256'(count_ones(2, 16)), 256'(1));
    chk({tag, "_x"}, x_log[11], exp_x);
  endtask

  localparam logic [255:0] PAT = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.start = 1'b0; bus.init_x = '0; bus.c_flat = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_x", bus.x_flat, '0);
    chk("reset_busy", 256'(bus.busy), 256'(0));
    chk("reset_done", 256'(bus.done), 256'(0));
    chk("reset_ctr_en", 256'(bus.ctr_en), 256'(0));
    rst = 1'b0;
    compare_on = 1'b1;

    // zero state
    do_load('0); bus.c_flat = '0;
    iterate(1, 0, 0, '0, 0, 16);
    check_single("zero", '0);

    // unit counters
    do_load('0); bus.c_flat = pack(32'h1, 32'h1);
    iterate(1, 0, 0, '0, 0, 16);
    check_single("unit", pack(32'h0002_0001, 32'h0000_0102));

    // wrap
    do_load('1); bus.c_flat = '0;
    iterate(1, 0, 0, '0, 0, 16);
    check_single("wrap", pack(32'hFFFF_FFFD, 32'hFFFF_FFFD));

    // rotation, start ignored at T+5
    do_load('0); bus.c_flat = pack(32'h0001_0000, 32'h0001_0000);
    iterate(1, 5, 0, '0, 0, 16);
    check_single("rot", pack(32'h0002_0001, 32'h0000_0102));

    // abort by load at T+6
    do_load('0); bus.c_flat = pack(32'h1, 32'h1);
    iterate(1, 0, 6, PAT, 0, 16);
    chk("abort_load_busy_T7", 256'(busy_log[7]), 256'(0));
    chk("abort_load_x_T7", x_log[7], PAT);
    chk("abort_load_no_done", 256'(count_ones(2, 16)), 256'(0));
    chk("abort_load_x_end", x_log[16], PAT);

    // abort by rst at T+4
    do_load(PAT);
    iterate(1, 0, 0, '0, 4, 16);
    chk("abort_rst_no_done", 256'(count_ones(2, 16)), 256'(0));
    chk("abort_rst_ctr_en_count", 256'(count_ones(0, 16)), 256'(1));
    chk("abort_rst_busy_T6", 256'(busy_log[6]), 256'(0));
    chk("abort_rst_x_end", x_log[16], '0);

    // load and start together: load only
    @(negedge clk); #1;
    bus.load = 1'b1; bus.start = 1'b1; bus.init_x = PAT;
    @(negedge clk); #1;
    bus.load = 1'b0; bus.start = 1'b0;
    chk("load_start_busy", 256'(bus.busy), 256'(0));
    chk("load_start_ctr_en", 256'(bus.ctr_en), 256'(0));
    chk("load_start_x", bus.x_flat, PAT);

    // back-to-back with start held
    do_load('0); bus.c_flat = pack(32'h1, 32'h1);
    iterate(22, 0, 0, '0, 0, 28);
    chk("b2b_done_T11", 256'(done_log[11]), 256'(1));
    chk("b2b_done_T22", 256'(done_log[22]), 256'(1));
    chk("b2b_done_count", 256'(count_ones(2, 28)), 256'(2));
    chk("b2b_ctr_en_T1", 256'(ce_log[1]), 256'(1));
    chk("b2b_ctr_en_T12", 256'(ce_log[12]), 256'(1));
    chk("b2b_ctr_en_count", 256'(count_ones(0, 28)), 256'(2));
    chk("b2b_x_first", x_log[11], pack(32'h0002_0001, 32'h0000_0102));

    repeat (3) @(negedge clk);
    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_state.md
NEXT_STATE -- requirements
Module: next_state

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  load init_x into state registers.
REQ-005 init_x  input  256  initial state words; word j at bits [32j+31:32j].
REQ-006 start  input  1  request one next-state iteration.
REQ-007 c_flat  input  256  current counter values c0..c7 from the eight counter stages; same word packing.
REQ-008 ctr_en  output  1  registered enable to all eight counter stages.
REQ-009 x_flat  output  256  state words x0..x7; same word packing.
REQ-010 busy  output  1  registered; high whenever FSM is not IDLE.
REQ-011 done  output  1  registered one-cycle pulse: new x_flat valid.

Function
REQ-012 The FSM SHALL have states IDLE, ADV, CALC, COMB.
REQ-013 IDLE with start=1 at cycle T SHALL go to ADV; start SHALL be ignored in every other state.
REQ-014 ADV (cycle T+1) SHALL drive ctr_en=1 for exactly that cycle, so counters advance at the end of T+1; the next state SHALL be CALC with j=0.
REQ-015 CALC SHALL run for 8 cycles (T+2..T+9) and compute one g_j per cycle, j=0..7, into an internal g register bank.
REQ-016 g_j: u=(x_j+c_j) mod 2^32; s=u*u as 64 bits; g_j = s[63:32] XOR s[31:0].
REQ-017 COMB (T+10) SHALL update all x words simultaneously; all sums mod 2^32; <<< is 32-bit rotate left.
- x0=g0+(g7<<<16)+(g6<<<16); x1=g1+(g0<<<8)+g7
- x2=g2+(g1<<<16)+(g0<<<16); x3=g3+(g2<<<8)+g1
- x4=g4+(g3<<<16)+(g2<<<16); x5=g5+(g4<<<8)+g3
- x6=g6+(g5<<<16)+(g4<<<16); x7=g7+(g6<<<8)+g5
REQ-018 After COMB the FSM SHALL return to IDLE with done=1 during T+11; start to done latency is 11 cycles.
REQ-019 busy SHALL be 1 during T+1..T+10 and 0 otherwise.
REQ-020 A start asserted in the done cycle SHALL be accepted; back-to-back iterations therefore occur every 11 cycles.
REQ-021 x_flat SHALL be stable except on load or at the end of COMB; CALC SHALL read only x registers and c_flat.
REQ-022 Priority SHALL be rst > load > FSM operation.
REQ-023 load in any state SHALL copy init_x to x, force IDLE, clear the g bank, and deassert ctr_en, busy and done on the next cycle.
REQ-024 load mid-iteration SHALL abort it with no done pulse. Counters already advanced are not rolled back.
REQ-025 load and start in the same cycle SHALL perform the load only; start is dropped.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, x=0, g bank=0, ctr_en=0, busy=0, done=0.
REQ-027 rst deasserted mid-iteration SHALL leave the FSM in IDLE; no done pulse and no ctr_en are issued for the aborted iteration.

Verification
REQ-028 Zero state: rst, then load init_x=0, hold c_flat=0, start -> ctr_en pulse at T+1, done at T+11, all x words 0x00000000.
REQ-029 Unit counters: x=0, c_j=0x00000001 for all j, start -> even words 0x00020001, odd words 0x00000102.
REQ-030 Wrap: x_j=0xFFFFFFFF, c_j=0 for all j (each g_j=0xFFFFFFFF), start -> every x word 0xFFFFFFFD.
REQ-031 Rotation: x=0, c_j=0x00010000 for all j (each g_j=0x00000001), start -> even words 0x00020001, odd words 0x00000102. Also check busy for exactly 10 cycles and start ignored at T+5.
REQ-032 Abort: load asserted at T+6 -> x=init_x, busy=0 from T+7, no done. Separately, rst at T+4 -> x=0 immediately, no done.
REQ-033 Back-to-back: start held continuously -> done at T+11 and T+22, with exactly two ctr_en pulses at T+1 and T+12.
